// File: rtl/uart_pkg.sv
// uart_pkg: shared scheduler state encoding and default widths for the UART TX scheduler slice.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } sched_state_e;

   localparam int DEF_SIZE    = 8;
   localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick of the first request at or above the pointer.
module uart_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic [NREQ-1:0]         o_grant,
   output logic [$clog2(NREQ)-1:0] o_idx,
   output logic                    o_valid
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] w_j;

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_j     = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_j = IW'((int'(i_ptr) + i) % NREQ);
         if (!o_valid && i_req[w_j]) begin
            o_valid      = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART TX between NREQ byte requesters.
// Define UART_SCHED_TIMEOUT_EN to abort a launch whose tx_busy never rises (err pulse).
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int SIZE    = DEF_SIZE,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*SIZE-1:0]    req_data,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done,
   output logic                    tx_en,
   output logic [SIZE-1:0]         data_in,
   input  logic                    tx_busy,
   output logic                    active,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    err
);

   localparam int IW = $clog2(NREQ);

   sched_state_e    r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] r_done;
   logic            r_txEn;
   logic            r_active;
   logic [SIZE-1:0] r_dataIn;

   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_idx;
   logic            w_valid;
   logic [SIZE-1:0] w_byte;
   logic [NREQ-1:0] w_ownerOh;
   logic [IW-1:0]   w_nextPtr;

`ifdef UART_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   r_count;
   logic            r_err;
`endif

   uart_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_byte    = req_data[w_idx*SIZE +: SIZE];
   assign w_ownerOh = NREQ'(1) << r_owner;
   assign w_nextPtr = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

   // Single registered FSM; grant/done/tx_en/err default low so they are one-cycle pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_txEn   <= 1'b0;
         r_active <= 1'b0;
         r_dataIn <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
         r_count  <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         r_grant <= '0;
         r_done  <= '0;
         r_txEn  <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         r_err   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant  <= w_grant;
                  r_owner  <= w_idx;
                  r_dataIn <= w_byte;
                  r_active <= 1'b1;
                  r_state  <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               r_txEn  <= 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
               r_count <= '0;
`endif
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end
`ifdef UART_SCHED_TIMEOUT_EN
               else if (r_count == CW'(TIMEOUT - 1)) begin
                  r_err    <= 1'b1;
                  r_done   <= w_ownerOh;
                  r_active <= 1'b0;
                  r_ptr    <= w_nextPtr;
                  r_state  <= ST_IDLE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
`endif
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  r_done   <= w_ownerOh;
                  r_active <= 1'b0;
                  r_ptr    <= w_nextPtr;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant   = r_grant;
   assign done    = r_done;
   assign tx_en   = r_txEn;
   assign data_in = r_dataIn;
   assign active  = r_active;
   assign owner   = r_owner;
`ifdef UART_SCHED_TIMEOUT_EN
   assign err     = r_err;
`else
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed vector table plus hand sequences for mid-frame request, reset and timeout.
module tb_uart_tx_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        tx_en;
   logic [7:0]  data_in;
   logic        tx_busy;
   logic        active;
   logic [1:0]  owner;
   logic        err;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  reqVec;
      logic [31:0] dataVec;
      int          busyLen;
      logic [3:0]  expGrant;
      logic [7:0]  expData;
   } vec_t;

   vec_t vecs[12];

   uart_tx_sched #(
      .SIZE    (8),
      .NREQ    (4),
      .TIMEOUT (64)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .done     (done),
      .tx_en    (tx_en),
      .data_in  (data_in),
      .tx_busy  (tx_busy),
      .active   (active),
      .owner    (owner),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the test finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [1:0] idxOf(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_grant"},   32'(grant),   32'h0);
      checkOutput({tag, "_done"},    32'(done),    32'h0);
      checkOutput({tag, "_tx_en"},   32'(tx_en),   32'h0);
      checkOutput({tag, "_active"},  32'(active),  32'h0);
      checkOutput({tag, "_err"},     32'(err),     32'h0);
      checkOutput({tag, "_owner"},   32'(owner),   32'h0);
      checkOutput({tag, "_data_in"}, 32'(data_in), 32'h0);
   endtask

   // One full transaction; midReq (if nonzero) is raised while the frame is in WAIT_DONE.
   task automatic applyStimulus(input logic [3:0] reqVec, input logic [31:0] dataVec, input int busyLen,
                                input logic [3:0] expGrant, input logic [7:0] expData,
                                input logic [3:0] midReq, input logic [31:0] midData, input string tag);
      int waitCycles;
      req        = reqVec;
      req_data   = dataVec;
      waitCycles = 0;
      do begin
         @(posedge clk); #1;
         waitCycles++;
      end while (grant == 4'b0 && waitCycles < 20);
      checkOutput({tag, "_grant"},   32'(grant),      32'(expGrant));
      checkOutput({tag, "_latency"}, 32'(waitCycles), 32'd1);
      checkOutput({tag, "_active"},  32'(active),     32'd1);
      checkOutput({tag, "_owner"},   32'(owner),      32'(idxOf(expGrant)));
      checkOutput({tag, "_data"},    32'(data_in),    32'(expData));
      checkOutput({tag, "_txen_at_grant"}, 32'(tx_en), 32'd0);
      req = '0;
      @(posedge clk); #1;
      checkOutput({tag, "_txen"},     32'(tx_en),   32'd1);
      checkOutput({tag, "_grant_off"},32'(grant),   32'd0);
      checkOutput({tag, "_data_tx"},  32'(data_in), 32'(expData));
      @(posedge clk); #1;
      checkOutput({tag, "_txen_off"}, 32'(tx_en),   32'd0);
      tx_busy = 1'b1;
      for (int i = 0; i < busyLen; i++) begin
         @(posedge clk); #1;
         if (midReq != 4'b0) begin
            req      = midReq;
            req_data = midData;
            checkOutput({tag, "_no_mid_grant"}, 32'(grant), 32'd0);
         end
      end
      checkOutput({tag, "_no_early_done"}, 32'(done),   32'd0);
      checkOutput({tag, "_busy_active"},   32'(active), 32'd1);
      tx_busy = 1'b0;
      @(posedge clk); #1;
      checkOutput({tag, "_done"},        32'(done),   32'(expGrant));
      checkOutput({tag, "_active_off"},  32'(active), 32'd0);
      checkOutput({tag, "_err"},         32'(err),    32'd0);
      checkOutput({tag, "_no_grant_at_done"}, 32'(grant), 32'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      req      = '0;
      req_data = '0;
      tx_busy  = 1'b0;

      vecs[0]  = '{4'b1111, 32'h13121110, 2,  4'b0001, 8'h10};
      vecs[1]  = '{4'b1111, 32'h13121110, 3,  4'b0010, 8'h11};
      vecs[2]  = '{4'b1111, 32'h13121110, 1,  4'b0100, 8'h12};
      vecs[3]  = '{4'b1111, 32'h13121110, 4,  4'b1000, 8'h13};
      vecs[4]  = '{4'b1111, 32'h13121110, 2,  4'b0001, 8'h10};
      vecs[5]  = '{4'b0010, 32'h0000A500, 10, 4'b0010, 8'hA5};
      vecs[6]  = '{4'b1000, 32'h5E000000, 2,  4'b1000, 8'h5E};
      vecs[7]  = '{4'b1001, 32'h7F0000E1, 3,  4'b0001, 8'hE1};
      vecs[8]  = '{4'b1001, 32'h7F0000E1, 1,  4'b1000, 8'h7F};
      vecs[9]  = '{4'b0110, 32'h00C4B200, 2,  4'b0010, 8'hB2};
      vecs[10] = '{4'b0101, 32'h00D600E7, 5,  4'b0100, 8'hD6};
      vecs[11] = '{4'b0011, 32'h0000F809, 2,  4'b0001, 8'h09};

      #1;
      checkAllZero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      checkAllZero("post_reset");

      for (int v = 0; v < 12; v++)
         applyStimulus(vecs[v].reqVec, vecs[v].dataVec, vecs[v].busyLen, vecs[v].expGrant,
                       vecs[v].expData, 4'b0, 32'h0, $sformatf("vec%0d", v));

      // Pointer is 1 here; requester 2 rises mid-frame and is served right after done.
      applyStimulus(4'b0010, 32'h00005A00, 4, 4'b0010, 8'h5A, 4'b0100, 32'h00C30000, "midA");
      applyStimulus(4'b0100, 32'h00C30000, 2, 4'b0100, 8'hC3, 4'b0, 32'h0, "midB");

      // Pointer is 3; start a frame and reset it during WAIT_BUSY.
      req      = 4'b0100;
      req_data = 32'h00990000;
      @(posedge clk); #1;
      checkOutput("rstf_grant", 32'(grant), 32'h4);
      req = '0;
      @(posedge clk); #1;
      checkOutput("rstf_txen", 32'(tx_en), 32'd1);
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      checkAllZero("midreset");
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus(4'b1001, 32'h11000022, 3, 4'b0001, 8'h22, 4'b0, 32'h0, "ptr_reset");
      applyStimulus(4'b1000, 32'h33000000, 2, 4'b1000, 8'h33, 4'b0, 32'h0, "after_reset");

`ifdef UART_SCHED_TIMEOUT_EN
      begin
         int k;
         req      = 4'b0010;
         req_data = 32'h00004400;
         @(posedge clk); #1;
         checkOutput("to_grant", 32'(grant), 32'h2);
         req = '0;
         @(posedge clk); #1;
         checkOutput("to_txen", 32'(tx_en), 32'd1);
         k = 0;
         while (err == 1'b0 && k < 200) begin
            @(posedge clk); #1;
            k++;
         end
         checkOutput("to_cycles", 32'(k),      32'd64);
         checkOutput("to_err",    32'(err),    32'd1);
         checkOutput("to_done",   32'(done),   32'h2);
         checkOutput("to_active", 32'(active), 32'd0);
         applyStimulus(4'b0001, 32'h00000055, 2, 4'b0001, 8'h55, 4'b0, 32'h0, "to_next");
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
